// File: rtl/caster_scan_gen.sv
// caster_scan_gen
//   EPD scan-timing generator with runtime-programmable V/H timing. The cfg_*
//   inputs are copied into shadow registers once per frame, at the frame
//   trigger. The block drives the gate/source control pins, N source-driver
//   chip enables, a pixel-request strobe that leads the active window, and a
//   registered SDCLK enable for an external ODDR.
// Ports
//   clk, rst          scan clock, asynchronous active-high reset
//   sys_ready         power OK / DDR calibrated; dropping it aborts a frame
//   vin_vsync         frame-start request (only honoured in IDLE)
//   cfg_v_*/cfg_h_*   vertical timing (lines) / horizontal timing (clocks)
//   cfg_h_seg         active clocks per source-driver chip
//   px_data           pixel beat, valid PIPE_DELAY clocks after px_req
//   px_req            fetch one beat of pixel data
//   b_trigger         high while waiting before the first line
//   frame_done        1-clock pulse after the last clock of a completed frame
//   cfg_err           sticky: the last latch attempt had an illegal config
//   epd_*             EPD gate/source pins; epd_sdce active low
module caster_scan_gen #(
  parameter int CNT_W      = 12,
  parameter int SD_W       = 8,
  parameter int NUM_SDCE   = 1,
  parameter int VS_DELAY   = 8,
  parameter int PIPE_DELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sys_ready,
  input  logic                vin_vsync,
  input  logic [CNT_W-1:0]    cfg_v_fp,
  input  logic [CNT_W-1:0]    cfg_v_sync,
  input  logic [CNT_W-1:0]    cfg_v_bp,
  input  logic [CNT_W-1:0]    cfg_v_act,
  input  logic [CNT_W-1:0]    cfg_h_fp,
  input  logic [CNT_W-1:0]    cfg_h_sync,
  input  logic [CNT_W-1:0]    cfg_h_bp,
  input  logic [CNT_W-1:0]    cfg_h_seg,
  input  logic [SD_W-1:0]     px_data,
  output logic                px_req,
  output logic                b_trigger,
  output logic                frame_done,
  output logic                cfg_err,
  output logic                epd_gdoe,
  output logic                epd_gdclk,
  output logic                epd_gdsp,
  output logic                epd_sdle,
  output logic                epd_sdoe,
  output logic                epd_sdclk_en,
  output logic [SD_W-1:0]     epd_sd,
  output logic [NUM_SDCE-1:0] epd_sdce
);
  // Four CNT_W terms (one scaled by up to 8 chips) always fit in CNT_W+4 bits.
  localparam int TW = CNT_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_e;
  typedef struct packed {
    logic [CNT_W-1:0] v_fp, v_sync, v_bp, v_act, h_fp, h_sync, h_bp, h_seg;
  } cfg_t;

  state_e              state_q, state_d;
  logic [TW-1:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  cfg_t                cfg_q, cfg_d, cfg_in;
  logic                cfg_err_q, cfg_err_d, frame_done_q, frame_done_d;
  logic                gdclk_q, gdclk_d, sdclk_en_q, sdclk_en_d;
  logic [SD_W-1:0]     sd_q, sd_d;
  logic [PIPE_DELAY:1] vld_pipe_q, vld_pipe_d;

  assign cfg_in = '{v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp, v_act: cfg_v_act,
                    h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp, h_seg: cfg_h_seg};

  // Region start points and totals, from the shadow copy only.
  logic [TW-1:0] v_sync_s, v_bp_s, v_act_s, v_tot, h_sync_s, h_bp_s, h_act_s, h_tot;
  assign v_sync_s = TW'(cfg_q.v_fp);
  assign v_bp_s   = v_sync_s + TW'(cfg_q.v_sync);
  assign v_act_s  = v_bp_s + TW'(cfg_q.v_bp);
  assign v_tot    = v_act_s + TW'(cfg_q.v_act);
  assign h_sync_s = TW'(cfg_q.h_fp);
  assign h_bp_s   = h_sync_s + TW'(cfg_q.h_sync);
  assign h_act_s  = h_bp_s + TW'(cfg_q.h_bp);
  assign h_tot    = h_act_s + TW'(cfg_q.h_seg) * TW'(NUM_SDCE);

  logic run, run_ok, last_h, last_v;
  logic vsync_r, vbp_r, vact_r, hfp_r, hsync_r, hbp_r, hact_r;
  assign run     = (state_q == S_RUN);
  assign run_ok  = run & sys_ready;
  assign last_h  = (h_cnt_q == h_tot - TW'(1));
  assign last_v  = (v_cnt_q == v_tot - TW'(1));
  assign vsync_r = run & (v_cnt_q >= v_sync_s) & (v_cnt_q < v_bp_s);
  assign vbp_r   = run & (v_cnt_q >= v_bp_s) & (v_cnt_q < v_act_s);
  assign vact_r  = run & (v_cnt_q >= v_act_s);
  assign hfp_r   = run & (h_cnt_q < h_sync_s);
  assign hsync_r = run & (h_cnt_q >= h_sync_s) & (h_cnt_q < h_bp_s);
  assign hbp_r   = run & (h_cnt_q >= h_bp_s) & (h_cnt_q < h_act_s);
  assign hact_r  = run & (h_cnt_q >= h_act_s);

  // Request window is the active window shifted early by the fetch latency;
  // assumes h_fp+h_sync+h_bp >= PIPE_DELAY so it never spills into the prior line.
  assign px_req = vact_r & (h_cnt_q >= h_act_s - TW'(PIPE_DELAY))
                         & (h_cnt_q <  h_tot   - TW'(PIPE_DELAY));

  // One active segment per source-driver chip, laid end to end.
  for (genvar k = 0; k < NUM_SDCE; k++) begin : g_sdce
    logic [TW-1:0] seg_lo, seg_hi;
    assign seg_lo      = h_act_s + TW'(cfg_q.h_seg) * TW'(k);
    assign seg_hi      = seg_lo + TW'(cfg_q.h_seg);
    assign epd_sdce[k] = ~(vact_r & (h_cnt_q >= seg_lo) & (h_cnt_q < seg_hi));
  end

  assign epd_gdoe     = vsync_r | vbp_r | vact_r;
  assign epd_sdoe     = vsync_r | vbp_r | vact_r;
  assign epd_gdsp     = ~vsync_r;
  assign epd_sdle     = hsync_r;
  assign b_trigger    = (state_q == S_WAIT);
  assign epd_gdclk    = gdclk_q;
  assign epd_sdclk_en = sdclk_en_q;
  assign epd_sd       = sd_q;
  assign frame_done   = frame_done_q;
  assign cfg_err      = cfg_err_q;

  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    cfg_d        = cfg_q;
    cfg_err_d    = cfg_err_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (sys_ready && vin_vsync) begin
        cfg_d = cfg_in;
        if (cfg_in.v_sync == '0 || cfg_in.v_act == '0 ||
            cfg_in.h_sync == '0 || cfg_in.h_seg == '0) begin
          cfg_err_d = 1'b1;
        end else begin
          cfg_err_d = 1'b0;
          state_d   = S_WAIT;
          h_cnt_d   = '0;
          v_cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!sys_ready) begin
          state_d = S_IDLE;
          h_cnt_d = '0;
        end else if (h_cnt_q == TW'(VS_DELAY)) begin
          state_d = S_RUN;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end else begin
          h_cnt_d = h_cnt_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!sys_ready) begin
          state_d = S_IDLE;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end else if (last_h) begin
          h_cnt_d = '0;
          if (last_v) begin
            state_d      = S_IDLE;
            v_cnt_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            v_cnt_d = v_cnt_q + TW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered pins are gated by run_ok so an abort lands on reset values.
    gdclk_d    = run_ok & (hsync_r | hbp_r | hact_r);
    sdclk_en_d = run_ok & (hfp_r | hsync_r | hact_r);
    // vld_pipe_q[PIPE_DELAY] marks the clock the requested beat is on px_data.
    sd_d       = (run_ok && vld_pipe_q[PIPE_DELAY]) ? px_data : '0;
    vld_pipe_d = '0;
    if (run_ok) begin
      vld_pipe_d[1] = px_req;
      for (int i = 2; i <= PIPE_DELAY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      cfg_q        <= '0;
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      gdclk_q      <= 1'b0;
      sdclk_en_q   <= 1'b0;
      sd_q         <= '0;
      vld_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      cfg_q        <= cfg_d;
      cfg_err_q    <= cfg_err_d;
      frame_done_q <= frame_done_d;
      gdclk_q      <= gdclk_d;
      sdclk_en_q   <= sdclk_en_d;
      sd_q         <= sd_d;
      vld_pipe_q   <= vld_pipe_d;
    end
  end
endmodule
